// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory handshake on one side, controller
// head/take/redirect on the other.
interface instr_fetch_queue_if #(
  parameter int AW = 16
);
  logic          fetch_en;
  logic          im_req;
  logic [AW-1:0] im_addr;
  logic          im_ack;
  logic [31:0]   im_data;
  logic [31:0]   ir;
  logic [5:0]    opcode;
  logic [AW-1:0] ir_pc;
  logic          i_odv;
  logic          i_take;
  logic          pc_load;
  logic [AW-1:0] pc_target;

  modport master (
    input  fetch_en, im_ack, im_data, i_take, pc_load, pc_target,
    output im_req, im_addr, ir, opcode, ir_pc, i_odv
  );

  modport slave (
    output fetch_en, im_ack, im_data, i_take, pc_load, pc_target,
    input  im_req, im_addr, ir, opcode, ir_pc, i_odv
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: one outstanding memory request feeding a small
// circular prefetch queue, with redirect flush and in-flight squash.
module instr_fetch_queue #(
  parameter int          AW       = 16,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input logic                 g_clk,
  input logic                 g_clr,
  instr_fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] RST_PC = AW'(RESET_PC);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t        state, state_n;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_post;
  logic [AW-1:0] fetch_pc, fetch_pc_n;
  logic [AW-1:0] req_addr, req_addr_n;
  logic [31:0]   q_ir [DEPTH];
  logic [AW-1:0] q_pc [DEPTH];
  logic          wr_en, take, flush, odv;
  logic [31:0]   ir_w;

  // A redirect flushes the queue, so a same-cycle take has nothing to pop.
  assign take       = bus.i_take && (count != '0) && !bus.pc_load;
  assign count_post = count + CW'(1) - CW'(take);

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    req_addr_n = req_addr;
    wr_en      = 1'b0;
    flush      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.pc_load) begin
          flush      = 1'b1;
          fetch_pc_n = bus.pc_target;
        end else if (bus.fetch_en && count < CW'(DEPTH)) begin
          req_addr_n = fetch_pc;
          state_n    = REQ;
        end
      end
      REQ: begin
        if (bus.pc_load) begin
          flush      = 1'b1;
          fetch_pc_n = bus.pc_target;
          state_n    = bus.im_ack ? IDLE : DISCARD;
        end else if (bus.im_ack) begin
          wr_en      = 1'b1;
          fetch_pc_n = req_addr + AW'(1);
          // Stream the next word back-to-back only if it is guaranteed a slot.
          if (bus.fetch_en && count_post < CW'(DEPTH))
            req_addr_n = req_addr + AW'(1);
          else
            state_n = IDLE;
        end
      end
      DISCARD: begin
        if (bus.pc_load) begin
          flush      = 1'b1;
          fetch_pc_n = bus.pc_target;
        end
        if (bus.im_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_clr) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= RST_PC;
      req_addr <= RST_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      req_addr <= req_addr_n;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PW'(1);
        if (take)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(wr_en) - CW'(take);
      end
    end
  end

  // Queue storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge g_clk) begin
    if (g_clr && wr_en) begin
      q_ir[wr_ptr] <= bus.im_data;
      q_pc[wr_ptr] <= req_addr;
    end
  end

  assign odv         = (count != '0);
  assign ir_w        = odv ? q_ir[rd_ptr] : 32'h0;
  assign bus.i_odv   = odv;
  assign bus.ir      = ir_w;
  assign bus.opcode  = ir_w[31:26];
  assign bus.ir_pc   = odv ? q_pc[rd_ptr] : '0;
  assign bus.im_req  = (state == REQ) || (state == DISCARD);
  assign bus.im_addr = req_addr;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench: bench acts as instruction memory and tracks the
// expected queue contents / fetch address with a queue-based model.
module tb_instr_fetch_queue;
  localparam int AW = 16;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0]   d;
    logic [AW-1:0] a;
  } ent_t;

  logic g_clk = 1'b0;
  logic g_clr = 1'b0;

  instr_fetch_queue_if #(.AW(AW)) bus();

  instr_fetch_queue #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .g_clk (g_clk),
    .g_clr (g_clr),
    .bus   (bus)
  );

  always #5 g_clk = ~g_clk;

  int checks = 0;
  int failures = 0;

  ent_t          mq[$];
  logic [AW-1:0] exp_pc = '0;
  bit            squash = 1'b0;
  int            ack_delay = 0;
  bit            ack_rand = 1'b0;
  int            wait_cnt = 0;

  function automatic logic [31:0] mem_word(logic [AW-1:0] a);
    return 32'(a) * 32'h01000001;
  endfunction

  // One clock: answer memory, check outputs against the model, advance model.
  task automatic cyc();
    logic          req, ack, pend;
    logic [AW-1:0] addr;
    logic [31:0]   e_ir;
    logic [AW-1:0] e_pc;
    bus.im_data = mem_word(bus.im_addr);
    if (ack_rand) bus.im_ack = bus.im_req && ($urandom % 2 == 0);
    else          bus.im_ack = bus.im_req && (wait_cnt >= ack_delay);
    e_ir = (mq.size() != 0) ? mq[0].d : 32'h0;
    e_pc = (mq.size() != 0) ? mq[0].a : '0;
    checks++;
    if (bus.i_odv !== (mq.size() != 0)) begin
      failures++; $display("FAIL m_odv got=%b exp=%b", bus.i_odv, mq.size() != 0);
    end
    checks++;
    if (bus.ir !== e_ir) begin
      failures++; $display("FAIL m_ir got=%h exp=%h", bus.ir, e_ir);
    end
    checks++;
    if (bus.opcode !== e_ir[31:26]) begin
      failures++; $display("FAIL m_opcode got=%h exp=%h", bus.opcode, e_ir[31:26]);
    end
    checks++;
    if (bus.ir_pc !== e_pc) begin
      failures++; $display("FAIL m_ir_pc got=%h exp=%h", bus.ir_pc, e_pc);
    end
    if (bus.im_req === 1'b1 && !squash) begin
      checks++;
      if (bus.im_addr !== exp_pc) begin
        failures++; $display("FAIL m_req_addr got=%h exp=%h", bus.im_addr, exp_pc);
      end
      checks++;
      if (mq.size() >= DEPTH) begin
        failures++; $display("FAIL m_req_full got=%0d exp=<%0d", mq.size(), DEPTH);
      end
    end
    req  = bus.im_req;
    ack  = bus.im_ack;
    addr = bus.im_addr;
    if (!g_clr) begin
      mq.delete(); exp_pc = '0; squash = 1'b0;
    end else if (bus.pc_load) begin
      mq.delete(); exp_pc = bus.pc_target; squash = req && !ack;
    end else begin
      if (bus.i_take && mq.size() != 0) void'(mq.pop_front());
      if (req && ack) begin
        if (squash) squash = 1'b0;
        else begin
          mq.push_back(ent_t'{mem_word(addr), addr});
          exp_pc = exp_pc + AW'(1);
        end
      end
    end
    pend = g_clr && req && !ack;
    @(posedge g_clk); #1;
    if (pend) begin
      checks++;
      if (bus.im_req !== 1'b1 || bus.im_addr !== addr) begin
        failures++; $display("FAIL m_req_hold got=%b/%h exp=1/%h", bus.im_req, bus.im_addr, addr);
      end
      wait_cnt++;
    end else wait_cnt = 0;
  endtask

  task automatic test_reset();
    g_clr = 1'b0;
    repeat (2) @(posedge g_clk);
    #1;
    checks++;
    if (bus.im_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", bus.im_req); end
    checks++;
    if (bus.i_odv !== 1'b0) begin failures++; $display("FAIL rst_odv got=%b exp=0", bus.i_odv); end
    checks++;
    if (bus.ir !== 32'h0) begin failures++; $display("FAIL rst_ir got=%h exp=0", bus.ir); end
    checks++;
    if (bus.ir_pc !== '0) begin failures++; $display("FAIL rst_ir_pc got=%h exp=0", bus.ir_pc); end
    checks++;
    if (bus.opcode !== 6'h0) begin failures++; $display("FAIL rst_opcode got=%h exp=0", bus.opcode); end
  endtask

  task automatic test_fill();
    ack_delay = 0; bus.fetch_en = 1'b1; g_clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (bus.im_req !== 1'b1 || bus.im_addr !== AW'(i)) begin
        failures++; $display("FAIL fill_addr%0d got=%b/%h exp=1/%h", i, bus.im_req, bus.im_addr, AW'(i));
      end
    end
    cyc();
    checks++;
    if (bus.im_req !== 1'b0 || bus.i_odv !== 1'b1 || bus.ir !== 32'h0 || bus.ir_pc !== '0) begin
      failures++; $display("FAIL fill_full got=%b/%b/%h/%h exp=0/1/0/0", bus.im_req, bus.i_odv, bus.ir, bus.ir_pc);
    end
    cyc();
    checks++;
    if (bus.im_req !== 1'b0) begin failures++; $display("FAIL fill_stay got=%b exp=0", bus.im_req); end
  endtask

  task automatic test_take_full();
    bus.i_take = 1'b1; cyc(); bus.i_take = 1'b0;
    checks++;
    if (bus.ir_pc !== AW'(1) || bus.im_req !== 1'b0) begin
      failures++; $display("FAIL take_head got=%h/%b exp=1/0", bus.ir_pc, bus.im_req);
    end
    cyc();
    checks++;
    if (bus.im_req !== 1'b1 || bus.im_addr !== AW'(4)) begin
      failures++; $display("FAIL take_req got=%b/%h exp=1/4", bus.im_req, bus.im_addr);
    end
    cyc();
    checks++;
    if (bus.im_req !== 1'b0) begin failures++; $display("FAIL take_refull got=%b exp=0", bus.im_req); end
    cyc();
    checks++;
    if (bus.im_req !== 1'b0) begin failures++; $display("FAIL take_norereq got=%b exp=0", bus.im_req); end
  endtask

  task automatic test_ack_delay();
    bus.fetch_en = 1'b0; bus.pc_load = 1'b1; bus.pc_target = 16'h0040;
    cyc(); bus.pc_load = 1'b0;
    checks++;
    if (bus.i_odv !== 1'b0) begin failures++; $display("FAIL dly_flush got=%b exp=0", bus.i_odv); end
    ack_delay = 3; bus.fetch_en = 1'b1;
    cyc(); bus.fetch_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.im_req !== 1'b1 || bus.im_addr !== 16'h0040) begin
        failures++; $display("FAIL dly_hold%0d got=%b/%h exp=1/0040", k, bus.im_req, bus.im_addr);
      end
      cyc();
    end
    checks++;
    if (bus.im_req !== 1'b0 || bus.i_odv !== 1'b1 || bus.ir_pc !== 16'h0040 || bus.ir !== mem_word(16'h0040)) begin
      failures++; $display("FAIL dly_entry got=%b/%b/%h/%h exp=0/1/0040/%h", bus.im_req, bus.i_odv, bus.ir_pc, bus.ir, mem_word(16'h0040));
    end
    bus.i_take = 1'b1; cyc(); bus.i_take = 1'b0;
    checks++;
    if (bus.i_odv !== 1'b0) begin failures++; $display("FAIL dly_single got=%b exp=0", bus.i_odv); end
    ack_delay = 0;
  endtask

  task automatic test_redirect_mid();
    bus.pc_load = 1'b1; bus.pc_target = '0; cyc(); bus.pc_load = 1'b0;
    bus.fetch_en = 1'b1;
    repeat (3) cyc();
    checks++;
    if (bus.im_req !== 1'b1 || bus.im_addr !== AW'(2) || bus.i_odv !== 1'b1) begin
      failures++; $display("FAIL redir_setup got=%b/%h/%b exp=1/0002/1", bus.im_req, bus.im_addr, bus.i_odv);
    end
    ack_delay = 1000;
    bus.pc_load = 1'b1; bus.pc_target = 16'h0100; cyc(); bus.pc_load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.i_odv !== 1'b0 || bus.im_req !== 1'b1 || bus.im_addr !== AW'(2)) begin
        failures++; $display("FAIL redir_discard%0d got=%b/%b/%h exp=0/1/0002", k, bus.i_odv, bus.im_req, bus.im_addr);
      end
      if (k < 2) cyc();
    end
    ack_delay = 0;
    cyc();
    checks++;
    if (bus.im_req !== 1'b0 || bus.i_odv !== 1'b0) begin
      failures++; $display("FAIL redir_drop got=%b/%b exp=0/0", bus.im_req, bus.i_odv);
    end
    cyc();
    checks++;
    if (bus.im_req !== 1'b1 || bus.im_addr !== 16'h0100) begin
      failures++; $display("FAIL redir_newreq got=%b/%h exp=1/0100", bus.im_req, bus.im_addr);
    end
    cyc();
    checks++;
    if (bus.i_odv !== 1'b1 || bus.ir_pc !== 16'h0100) begin
      failures++; $display("FAIL redir_first got=%b/%h exp=1/0100", bus.i_odv, bus.ir_pc);
    end
  endtask

  task automatic test_load_ack();
    bus.i_take = 1'b1; bus.fetch_en = 1'b1; ack_delay = 0;
    for (int k = 0; k < 20 && bus.im_req !== 1'b1; k++) cyc();
    checks++;
    if (bus.im_req !== 1'b1) begin failures++; $display("FAIL ldack_wait got=%b exp=1", bus.im_req); end
    bus.pc_load = 1'b1; bus.pc_target = 16'h0300; cyc(); bus.pc_load = 1'b0;
    checks++;
    if (bus.im_req !== 1'b0 || bus.i_odv !== 1'b0) begin
      failures++; $display("FAIL ldack_drop got=%b/%b exp=0/0", bus.im_req, bus.i_odv);
    end
    cyc();
    checks++;
    if (bus.im_req !== 1'b1 || bus.im_addr !== 16'h0300) begin
      failures++; $display("FAIL ldack_req got=%b/%h exp=1/0300", bus.im_req, bus.im_addr);
    end
    cyc();
    checks++;
    if (bus.i_odv !== 1'b1 || bus.ir_pc !== 16'h0300) begin
      failures++; $display("FAIL ldack_first got=%b/%h exp=1/0300", bus.i_odv, bus.ir_pc);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] got [3];
    logic [AW-1:0] wexp [3];
    int n = 0;
    wexp[0] = 16'hFFFE; wexp[1] = 16'hFFFF; wexp[2] = 16'h0000;
    bus.i_take = 1'b1; bus.fetch_en = 1'b1; ack_delay = 0;
    bus.pc_load = 1'b1; bus.pc_target = 16'hFFFE; cyc(); bus.pc_load = 1'b0;
    for (int k = 0; k < 20 && n < 3; k++) begin
      if (bus.im_req === 1'b1 && (n == 0 || bus.im_addr !== got[n-1])) begin
        got[n] = bus.im_addr; n++;
      end
      cyc();
    end
    checks++;
    if (n != 3) begin failures++; $display("FAIL wrap_count got=%0d exp=3", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got[i] !== wexp[i]) begin failures++; $display("FAIL wrap_addr%0d got=%h exp=%h", i, got[i], wexp[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bus.i_take = 1'b0; bus.fetch_en = 1'b0; ack_delay = 0;
    bus.pc_load = 1'b1; bus.pc_target = 16'h0050; cyc(); bus.pc_load = 1'b0;
    bus.fetch_en = 1'b1;
    for (int k = 0; k < 10 && !(bus.im_req === 1'b1 && bus.im_addr === 16'h0050); k++) cyc();
    cyc(); cyc();
    ack_delay = 1000;
    checks++;
    if (bus.im_req !== 1'b1 || bus.im_addr !== 16'h0052 || bus.i_odv !== 1'b1 || bus.ir_pc !== 16'h0050) begin
      failures++; $display("FAIL rmid_setup got=%b/%h/%b/%h exp=1/0052/1/0050", bus.im_req, bus.im_addr, bus.i_odv, bus.ir_pc);
    end
    g_clr = 1'b0; cyc();
    checks++;
    if (bus.im_req !== 1'b0 || bus.i_odv !== 1'b0 || bus.ir !== 32'h0) begin
      failures++; $display("FAIL rmid_clear got=%b/%b/%h exp=0/0/0", bus.im_req, bus.i_odv, bus.ir);
    end
    g_clr = 1'b1; ack_delay = 0; cyc();
    checks++;
    if (bus.im_req !== 1'b1 || bus.im_addr !== '0) begin
      failures++; $display("FAIL rmid_restart got=%b/%h exp=1/0000", bus.im_req, bus.im_addr);
    end
  endtask

  task automatic test_random();
    ack_rand = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      bus.fetch_en  = ($urandom % 4) != 0;
      bus.i_take    = ($urandom % 2) == 0;
      bus.pc_load   = ($urandom % 16) == 0;
      bus.pc_target = AW'($urandom);
      g_clr         = ($urandom % 200) != 0;
      cyc();
    end
    g_clr = 1'b1; bus.pc_load = 1'b0; ack_rand = 1'b0;
  endtask

  initial begin
    bus.fetch_en = 1'b0; bus.im_ack = 1'b0; bus.im_data = '0;
    bus.i_take = 1'b0; bus.pc_load = 1'b0; bus.pc_target = '0;
    test_reset();
    test_fill();
    test_take_full();
    test_ack_delay();
    test_redirect_mid();
    test_load_ack();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Instruction fetch stage sitting directly upstream of the processor controller.
- Fetches 32-bit instruction words from instruction memory over a req/ack handshake into a small prefetch queue.
- Presents the head instruction as ir/opcode with i_odv; the controller consumes it with i_take.
- Supports PC redirect (branch/jump/interrupt vector) with queue flush and squash of any in-flight fetch.

Parameters:
AW, 16, instruction address width (word addresses)
DEPTH, 4, prefetch queue entries (power of two, >=2)
RESET_PC, 0, fetch address after reset

Ports:
g_clk  in  1  global clock, all state updates on rising edge
g_clr  in  1  global clear; synchronous, active-low
fetch_en  in  1  1 = new fetch requests may be started
im_req  out  1  memory request
im_addr  out  AW  memory word address; stable while im_req=1
im_ack  in  1  memory completes request this cycle; im_data valid
im_data  in  32  instruction word
ir  out  32  head-of-queue instruction; 0 when queue empty
opcode  out  6  ir[31:26]
ir_pc  out  AW  address of head instruction; 0 when empty
i_odv  out  1  head valid (queue non-empty)
i_take  in  1  controller consumes head this cycle
pc_load  in  1  redirect fetch
pc_target  in  AW  redirect address

Behaviour:
- Reset (g_clr=0 at an edge): state IDLE, queue empty (rd/wr ptr 0, count 0), fetch_pc=RESET_PC, req_addr=RESET_PC. Outputs im_req=0, i_odv=0, ir=0, opcode=0, ir_pc=0. Reset has priority over all inputs, including mid-request. A pending memory ack after reset is ignored because im_req=0.
- Queue: circular buffer, DEPTH entries, each holding {instruction, address}. Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Outputs are combinational from registered state:
  - i_odv = (count!=0).
  - ir/ir_pc = head entry, or 0 when empty.
  - im_req = (state==REQ || state==DISCARD).
  - im_addr = req_addr.
- FSM states: IDLE, REQ, DISCARD.
- IDLE:
  - If fetch_en && count<DEPTH && !pc_load: req_addr<=fetch_pc, go to REQ.
  - A pc_load in IDLE only updates fetch_pc and flushes the queue.
- REQ: im_req=1, req_addr held constant.
  - Ack without pc_load: write {im_data, req_addr} at wr_ptr; fetch_pc<=req_addr+1.
    - If fetch_en and post-update count<DEPTH: req_addr<=req_addr+1, stay in REQ. This streams one word per cycle with zero-wait memory.
    - Otherwise go to IDLE.
  - No ack: stay in REQ.
- Redirect (pc_load=1) in any state:
  - Queue flushed that cycle; i_take ignored.
  - fetch_pc<=pc_target.
  - If in REQ and im_ack=1 the same cycle: data discarded, go to IDLE.
  - If in REQ and im_ack=0: go to DISCARD.
- DISCARD: im_req stays 1 with the old req_addr until ack. Acked data is dropped, then go to IDLE. Further pc_load in DISCARD only updates fetch_pc.
- i_take with count=0: ignored. Simultaneous take and write: count unchanged, both pointers advance.
- Full: no request is started while count==DEPTH. Because only one request is ever outstanding, an ack always finds space.
- Address arithmetic wraps modulo 2^AW (0xFFFF+1 -> 0x0000 for AW=16).
- Latency with zero-wait memory: request asserted 1 cycle after the triggering condition; word visible on i_odv the cycle after its ack.

Test Plan:
- Reset release, fetch_en=1, im_ack always 1, mem[a]=a*0x01000001, no take:
  - im_req rises 1 cycle after reset.
  - Addresses 0,1,2,3 fetched on consecutive cycles.
  - i_odv=1 with ir=0x00000000, ir_pc=0.
  - im_req drops once count=4.
- Full queue, single i_take pulse: head advances to ir_pc=1. Exactly one new request at address 4, acked into the freed slot; count returns to 4.
- im_ack delayed 3 cycles: im_addr stays constant for all 4 request cycles; a single entry is written.
- Redirect mid-request: pc_load=1, pc_target=0x0100 while REQ at addr 2 with im_ack=0.
  - i_odv=0 next cycle; im_req stays 1 at addr 2 until ack.
  - That data is dropped; the next request is at 0x0100 and the first valid ir_pc=0x0100.
- pc_load and im_ack in the same cycle: acked word not enqueued; next request at pc_target.
- pc_target=0xFFFE, continuous take: fetched addresses 0xFFFE, 0xFFFF, 0x0000.
- g_clr=0 asserted mid-request with queue holding 2 entries: next cycle im_req=0, i_odv=0, ir=0. After release, the first request is at RESET_PC.
